// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
// Registered multicycle control unit for the 16-opcode accumulator/stack CPU.
// A one-hot state register sequences each instruction. Datapath strobes and
// mux selects are decoded combinationally from the current state, opcode,
// operand flag and memory ready. Three additions over a plain decoder:
//   - memory-ready stall handshake in every state that waits on memory,
//   - a stall watchdog that forces ERR and latches a sticky error report,
//   - a retired-instruction counter.
//
// Ports
//   CLK, RSTn            clock, asynchronous active-low reset
//   Op, LMC, Perform     opcode, operand-is-memory flag, predicate (DEC only)
//   MemRdy               memory completed the current access
//   ClrErr               synchronous clear of Error/ErrOp/ErrState
//   PCW MW IW RW FU SPW  write strobes (inactive 0)
//   Jump LM IorD MSrc SrcB SPIorD  2-bit selects (inactive 2'b10)
//   RWSrc ALUOp          4-bit selects (inactive 4'b1000)
//   State                one-hot state, bit 0 = RST ... bit 9 = ERR
//   Retired              completed-instruction count, wraps
//   Error ErrOp ErrState sticky error flag and first-error capture
//
// state | meaning
// ------+------------------------------------------------------------
// RST   | held in reset; leaves on the first clock after release
// FETCH | instruction read, waits on MemRdy
// DEC   | decode; POP and J also wait on MemRdy here
// LDM   | memory operand read, waits on MemRdy
// EXE   | ALU operation, write-back or flag update
// MWR   | memory write (STO, PUSH), waits on MemRdy
// CP    | register copy write-back
// JMP   | PC update for JR and J
// POP   | stack pointer update and register write-back
// ERR   | watchdog trip or illegal state; halts or restarts at FETCH
module multicycle_ctrl_fsm #(
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 15,
   parameter bit ERR_HALT = 1'b1
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic [3:0]       Op,
   input  logic             LMC,
   input  logic             Perform,
   input  logic             MemRdy,
   input  logic             ClrErr,
   output logic             PCW,
   output logic             MW,
   output logic             IW,
   output logic             RW,
   output logic             FU,
   output logic             SPW,
   output logic [1:0]       Jump,
   output logic [1:0]       LM,
   output logic [1:0]       IorD,
   output logic [1:0]       MSrc,
   output logic [1:0]       SrcB,
   output logic [1:0]       SPIorD,
   output logic [3:0]       RWSrc,
   output logic [3:0]       ALUOp,
   output logic [9:0]       State,
   output logic [CNT_W-1:0] Retired,
   output logic             Error,
   output logic [3:0]       ErrOp,
   output logic [9:0]       ErrState
);

   typedef enum logic [9:0] {
      S_RST   = 10'b00_0000_0001,
      S_FETCH = 10'b00_0000_0010,
      S_DEC   = 10'b00_0000_0100,
      S_LDM   = 10'b00_0000_1000,
      S_EXE   = 10'b00_0001_0000,
      S_MWR   = 10'b00_0010_0000,
      S_CP    = 10'b00_0100_0000,
      S_JMP   = 10'b00_1000_0000,
      S_POP   = 10'b01_0000_0000,
      S_ERR   = 10'b10_0000_0000
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'h0, OP_ADDI = 4'h1, OP_STO = 4'h2, OP_LUI  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4, OP_CMP  = 4'h5, OP_CP  = 4'h6, OP_CPI  = 4'h7;
   localparam logic [3:0] OP_AND  = 4'h8, OP_XOR  = 4'h9, OP_PUSH = 4'hA, OP_POP = 4'hB;
   localparam logic [3:0] OP_OR   = 4'hC, OP_ORI  = 4'hD, OP_JR  = 4'hE, OP_J    = 4'hF;

   localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   localparam logic [1:0] SEL_OFF = 2'b10;
   localparam logic [3:0] SEL4_OFF = 4'b1000;

   state_t              state;
   state_t              state_nxt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                dec_mem_wait;
   logic                waiting;
   logic                wd_trip;
   logic                retire_src;

   assign State = state;

   // POP and J read memory straight out of DEC, so DEC becomes a wait state
   // for them (only when the instruction is actually performed).
   assign dec_mem_wait = Perform && ((Op == OP_POP) || (Op == OP_J));
   assign waiting      = (state == S_FETCH) || (state == S_LDM) || (state == S_MWR) ||
                         ((state == S_DEC) && dec_mem_wait);
   assign wd_trip      = waiting && !MemRdy && (wait_cnt == WAIT_MAX);
   assign retire_src   = (state == S_DEC) || (state == S_EXE) || (state == S_MWR) ||
                         (state == S_CP)  || (state == S_JMP) || (state == S_POP);

   // Destination for register-operand forms; LDM reuses it once the operand is in.
   function automatic state_t reg_route(input logic [3:0] op);
      case (op)
         OP_STO:  reg_route = S_MWR;
         OP_CP:   reg_route = S_CP;
         OP_JR:   reg_route = S_JMP;
         default: reg_route = S_EXE;
      endcase
   endfunction

   always_comb begin
      state_nxt = state;
      case (state)
         S_RST:   state_nxt = S_FETCH;
         S_FETCH: begin
            if (MemRdy)       state_nxt = S_DEC;
            else if (wd_trip) state_nxt = S_ERR;
         end
         S_DEC: begin
            if (!Perform) begin
               state_nxt = S_FETCH;
            end else begin
               case (Op)
                  OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_XOR, OP_OR,
                  OP_STO, OP_CP, OP_JR:    state_nxt = LMC ? S_LDM : reg_route(Op);
                  OP_ADDI, OP_ORI:         state_nxt = S_EXE;
                  OP_LUI, OP_CPI:          state_nxt = S_FETCH;
                  OP_PUSH:                 state_nxt = S_MWR;
                  OP_POP: begin
                     if (MemRdy)       state_nxt = S_POP;
                     else if (wd_trip) state_nxt = S_ERR;
                  end
                  OP_J: begin
                     if (MemRdy)       state_nxt = S_JMP;
                     else if (wd_trip) state_nxt = S_ERR;
                  end
                  default:                 state_nxt = S_FETCH;
               endcase
            end
         end
         S_LDM: begin
            if (MemRdy)       state_nxt = reg_route(Op);
            else if (wd_trip) state_nxt = S_ERR;
         end
         S_MWR: begin
            if (MemRdy)       state_nxt = S_FETCH;
            else if (wd_trip) state_nxt = S_ERR;
         end
         S_EXE, S_CP, S_JMP, S_POP: state_nxt = S_FETCH;
         S_ERR:   state_nxt = ERR_HALT ? S_ERR : S_FETCH;
         default: state_nxt = S_ERR;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state    <= S_RST;
         wait_cnt <= '0;
         Retired  <= '0;
         Error    <= 1'b0;
         ErrOp    <= 4'h0;
         ErrState <= 10'h000;
      end else begin
         state <= state_nxt;

         if (state_nxt != state)
            wait_cnt <= '0;
         else if (waiting && !MemRdy)
            wait_cnt <= wait_cnt + WAIT_W'(1);

         if ((state_nxt == S_FETCH) && retire_src)
            Retired <= Retired + CNT_W'(1);

         // First error wins; a capture in the same cycle overrides ClrErr.
         if ((state_nxt == S_ERR) && (state != S_ERR) && !Error) begin
            Error    <= 1'b1;
            ErrOp    <= Op;
            ErrState <= state;
         end else if (ClrErr) begin
            Error    <= 1'b0;
            ErrOp    <= 4'h0;
            ErrState <= 10'h000;
         end
      end
   end

   always_comb begin
      PCW    = 1'b0;
      MW     = 1'b0;
      IW     = 1'b0;
      RW     = 1'b0;
      FU     = 1'b0;
      SPW    = 1'b0;
      Jump   = SEL_OFF;
      LM     = SEL_OFF;
      IorD   = SEL_OFF;
      MSrc   = SEL_OFF;
      SrcB   = SEL_OFF;
      SPIorD = SEL_OFF;
      RWSrc  = SEL4_OFF;
      ALUOp  = SEL4_OFF;
      case (state)
         S_FETCH: begin
            IorD = 2'd1;
            PCW  = MemRdy;
         end
         S_DEC: begin
            // IR write is held off while POP/J stall on memory.
            IW = !(dec_mem_wait && !MemRdy);
            if (Perform) begin
               case (Op)
                  OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_XOR, OP_OR,
                  OP_STO, OP_CP, OP_JR: LM = 2'd0;
                  OP_LUI: begin
                     RW    = 1'b1;
                     RWSrc = 4'd5;
                  end
                  OP_CPI: begin
                     RW    = 1'b1;
                     RWSrc = 4'd7;
                  end
                  OP_PUSH: begin
                     LM     = 2'd0;
                     SPW    = 1'b1;
                     SPIorD = 2'd0;
                  end
                  OP_POP: begin
                     LM   = 2'd1;
                     IorD = 2'd0;
                     MSrc = 2'd0;
                  end
                  OP_J: begin
                     LM   = 2'd1;
                     IorD = 2'd1;
                     PCW  = MemRdy;
                  end
                  default: ;
               endcase
            end
         end
         S_LDM: begin
            LM   = 2'd1;
            IorD = 2'd0;
            MSrc = 2'd1;
         end
         S_EXE: begin
            if (Op == OP_CMP) begin
               FU = 1'b1;
            end else begin
               RW    = 1'b1;
               RWSrc = 4'd0;
            end
            SrcB = ((Op == OP_ADDI) || (Op == OP_ORI)) ? 2'd1 : 2'd0;
            case (Op)
               OP_ADD:  ALUOp = 4'd0;
               OP_ADDI: ALUOp = 4'd1;
               OP_SUB:  ALUOp = 4'd2;
               OP_CMP:  ALUOp = 4'd3;
               OP_AND:  ALUOp = 4'd4;
               OP_XOR:  ALUOp = 4'd5;
               OP_OR:   ALUOp = 4'd6;
               OP_ORI:  ALUOp = 4'd7;
               default: ALUOp = SEL4_OFF;
            endcase
         end
         S_MWR: begin
            IorD = 2'd0;
            MSrc = (Op == OP_STO) ? 2'd1 : 2'd0;
            MW   = MemRdy;
         end
         S_CP: begin
            RW    = 1'b1;
            RWSrc = 4'd1;
         end
         S_JMP: begin
            PCW  = 1'b1;
            Jump = 2'd1;
            if ((Op == OP_J) && LMC) begin
               RW    = 1'b1;
               RWSrc = 4'd3;
            end
         end
         S_POP: begin
            SPW    = 1'b1;
            SPIorD = 2'd1;
            RW     = 1'b1;
            RWSrc  = 4'd1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm (CNT_W=4 so the retired counter wraps,
// MAX_WAIT=15, ERR_HALT=1). The driver walks each instruction through the
// phase list the instruction should take, pushes the expected outputs of
// every cycle into a queue, and a negedge monitor pops and compares.
module tb_multicycle_ctrl_fsm;

   localparam int P_RST = 0, P_FETCH = 1, P_DEC = 2, P_LDM = 3, P_EXE = 4;
   localparam int P_MWR = 5, P_CP = 6, P_JMP = 7, P_POP = 8, P_ERR = 9;

   localparam logic [3:0] OP_ADD  = 4'h0, OP_ADDI = 4'h1, OP_STO = 4'h2, OP_LUI  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4, OP_CMP  = 4'h5, OP_CP  = 4'h6, OP_CPI  = 4'h7;
   localparam logic [3:0] OP_AND  = 4'h8, OP_XOR  = 4'h9, OP_PUSH = 4'hA, OP_POP = 4'hB;
   localparam logic [3:0] OP_OR   = 4'hC, OP_ORI  = 4'hD, OP_JR  = 4'hE, OP_J    = 4'hF;

   typedef struct packed {
      logic [9:0]  st;
      logic [5:0]  wr;     // {PCW,MW,IW,RW,FU,SPW}
      logic [11:0] sel;    // {Jump,LM,IorD,MSrc,SrcB,SPIorD}
      logic [3:0]  rwsrc;
      logic [3:0]  aluop;
      logic [3:0]  ret;
      logic        err;
      logic [3:0]  errop;
      logic [9:0]  errst;
   } item_t;

   logic CLK = 1'b0;
   logic RSTn = 1'b0;
   logic [3:0] Op = 4'h0;
   logic LMC = 1'b0, Perform = 1'b0, MemRdy = 1'b0, ClrErr = 1'b0;
   logic PCW, MW, IW, RW, FU, SPW;
   logic [1:0] Jump, LM, IorD, MSrc, SrcB, SPIorD;
   logic [3:0] RWSrc, ALUOp;
   logic [9:0] State;
   logic [3:0] Retired;
   logic Error;
   logic [3:0] ErrOp;
   logic [9:0] ErrState;

   int checks = 0;
   int failures = 0;

   item_t q[$];
   int    plan[$];
   logic [3:0] exp_ret = 4'h0;
   logic       exp_err = 1'b0;
   logic [3:0] exp_errop = 4'h0;
   logic [9:0] exp_errst = 10'h0;

   multicycle_ctrl_fsm #(.CNT_W(4), .MAX_WAIT(15), .ERR_HALT(1'b1)) dut (
      .CLK(CLK), .RSTn(RSTn), .Op(Op), .LMC(LMC), .Perform(Perform),
      .MemRdy(MemRdy), .ClrErr(ClrErr),
      .PCW(PCW), .MW(MW), .IW(IW), .RW(RW), .FU(FU), .SPW(SPW),
      .Jump(Jump), .LM(LM), .IorD(IorD), .MSrc(MSrc), .SrcB(SrcB), .SPIorD(SPIorD),
      .RWSrc(RWSrc), .ALUOp(ALUOp), .State(State), .Retired(Retired),
      .Error(Error), .ErrOp(ErrOp), .ErrState(ErrState)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Expected outputs for one cycle spent in phase p.
   function automatic item_t model_out(input int p, input logic [3:0] op, input logic lmc,
                                       input logic perf, input logic rdy);
      item_t e;
      logic pcw, mw, iw, rw, fu, spw;
      logic [1:0] jump, lm, iord, msrc, srcb, spiord;
      e = '0;
      {pcw, mw, iw, rw, fu, spw} = 6'b0;
      {jump, lm, iord, msrc, srcb, spiord} = {6{2'b10}};
      e.rwsrc = 4'h8;
      e.aluop = 4'h8;
      case (p)
         P_FETCH: begin iord = 2'd1; pcw = rdy; end
         P_DEC: begin
            iw = !(perf && (op == OP_POP || op == OP_J) && !rdy);
            if (perf) begin
               case (op)
                  OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_XOR, OP_OR, OP_STO, OP_CP, OP_JR: lm = 2'd0;
                  OP_LUI:  begin rw = 1'b1; e.rwsrc = 4'd5; end
                  OP_CPI:  begin rw = 1'b1; e.rwsrc = 4'd7; end
                  OP_PUSH: begin lm = 2'd0; spw = 1'b1; spiord = 2'd0; end
                  OP_POP:  begin lm = 2'd1; iord = 2'd0; msrc = 2'd0; end
                  OP_J:    begin lm = 2'd1; iord = 2'd1; pcw = rdy; end
                  default: ;
               endcase
            end
         end
         P_LDM: begin lm = 2'd1; iord = 2'd0; msrc = 2'd1; end
         P_EXE: begin
            if (op == OP_CMP) fu = 1'b1;
            else begin rw = 1'b1; e.rwsrc = 4'd0; end
            srcb = (op == OP_ADDI || op == OP_ORI) ? 2'd1 : 2'd0;
            case (op)
               OP_ADD: e.aluop = 4'd0;  OP_ADDI: e.aluop = 4'd1;
               OP_SUB: e.aluop = 4'd2;  OP_CMP:  e.aluop = 4'd3;
               OP_AND: e.aluop = 4'd4;  OP_XOR:  e.aluop = 4'd5;
               OP_OR:  e.aluop = 4'd6;  OP_ORI:  e.aluop = 4'd7;
               default: ;
            endcase
         end
         P_MWR: begin iord = 2'd0; msrc = (op == OP_STO) ? 2'd1 : 2'd0; mw = rdy; end
         P_CP:  begin rw = 1'b1; e.rwsrc = 4'd1; end
         P_JMP: begin
            pcw = 1'b1; jump = 2'd1;
            if (op == OP_J && lmc) begin rw = 1'b1; e.rwsrc = 4'd3; end
         end
         P_POP: begin spw = 1'b1; spiord = 2'd1; rw = 1'b1; e.rwsrc = 4'd1; end
         default: ;
      endcase
      e.st  = 10'd1 << p;
      e.wr  = {pcw, mw, iw, rw, fu, spw};
      e.sel = {jump, lm, iord, msrc, srcb, spiord};
      return e;
   endfunction

   // Sequence of phases an instruction passes through.
   function automatic void make_plan(input logic [3:0] op, input logic lmc, input logic perf);
      plan.delete();
      plan.push_back(P_FETCH);
      plan.push_back(P_DEC);
      if (!perf) return;
      case (op)
         OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_XOR, OP_OR: begin
            if (lmc) plan.push_back(P_LDM);
            plan.push_back(P_EXE);
         end
         OP_STO: begin if (lmc) plan.push_back(P_LDM); plan.push_back(P_MWR); end
         OP_CP:  begin if (lmc) plan.push_back(P_LDM); plan.push_back(P_CP);  end
         OP_JR:  begin if (lmc) plan.push_back(P_LDM); plan.push_back(P_JMP); end
         OP_ADDI, OP_ORI: plan.push_back(P_EXE);
         OP_PUSH: plan.push_back(P_MWR);
         OP_POP:  plan.push_back(P_POP);
         OP_J:    plan.push_back(P_JMP);
         default: ;
      endcase
   endfunction

   function automatic bit is_wait(input int p, input logic [3:0] op, input logic perf);
      return (p == P_FETCH) || (p == P_LDM) || (p == P_MWR) ||
             ((p == P_DEC) && perf && (op == OP_POP || op == OP_J));
   endfunction

   task automatic push_item(input item_t e_in);
      item_t e;
      e = e_in;
      e.ret = exp_ret;
      e.err = exp_err;
      e.errop = exp_errop;
      e.errst = exp_errst;
      q.push_back(e);
   endtask

   task automatic model_reset();
      exp_ret = 4'h0; exp_err = 1'b0; exp_errop = 4'h0; exp_errst = 10'h0;
   endtask

   task automatic do_reset();
      @(posedge CLK); #1;
      RSTn = 1'b0;
      model_reset();
      push_item(model_out(P_RST, 4'h0, 1'b0, 1'b0, 1'b0));
      @(posedge CLK); #1;
      push_item(model_out(P_RST, 4'h0, 1'b0, 1'b0, 1'b0));
      RSTn = 1'b1;
   endtask

   // st_fetch: stall cycles in FETCH; st_mid: stall cycles in every later wait phase.
   task automatic issue(input logic [3:0] op, input logic lmc, input logic perf,
                        input int st_fetch, input int st_mid);
      make_plan(op, lmc, perf);
      foreach (plan[i]) begin
         int  p;
         bit  w;
         int  s;
         logic rdy;
         p = plan[i];
         w = is_wait(p, op, perf);
         s = w ? ((p == P_FETCH) ? st_fetch : st_mid) : 0;
         for (int k = 0; k <= s; k++) begin
            @(posedge CLK); #1;
            Op = op; LMC = lmc; Perform = perf;
            rdy = w ? (k == s) : 1'($urandom % 2);
            MemRdy = rdy;
            push_item(model_out(p, op, lmc, perf, rdy));
         end
      end
      exp_ret = exp_ret + 4'd1;
   endtask

   task automatic mid_reset();
      @(posedge CLK); #1;
      Op = OP_ADD; LMC = 1'b1; Perform = 1'b1; MemRdy = 1'b1;
      push_item(model_out(P_FETCH, OP_ADD, 1'b1, 1'b1, 1'b1));
      @(posedge CLK); #1;
      push_item(model_out(P_DEC, OP_ADD, 1'b1, 1'b1, 1'b1));
      @(posedge CLK); #1;
      MemRdy = 1'b1;
      #2;
      RSTn = 1'b0;
      model_reset();
      push_item(model_out(P_RST, 4'h0, 1'b0, 1'b0, 1'b0));
      @(posedge CLK); #1;
      push_item(model_out(P_RST, 4'h0, 1'b0, 1'b0, 1'b0));
      RSTn = 1'b1;
   endtask

   task automatic err_test();
      for (int k = 0; k < 16; k++) begin
         @(posedge CLK); #1;
         Op = OP_LUI; LMC = 1'b0; Perform = 1'b1; MemRdy = 1'b0;
         push_item(model_out(P_FETCH, OP_LUI, 1'b0, 1'b1, 1'b0));
      end
      exp_err = 1'b1; exp_errop = OP_LUI; exp_errst = 10'b00_0000_0010;
      for (int k = 0; k < 4; k++) begin
         @(posedge CLK); #1;
         MemRdy = 1'($urandom % 2);
         push_item(model_out(P_ERR, OP_LUI, 1'b0, 1'b1, MemRdy));
      end
      @(posedge CLK); #1;
      ClrErr = 1'b1;
      push_item(model_out(P_ERR, OP_LUI, 1'b0, 1'b1, MemRdy));
      @(posedge CLK); #1;
      ClrErr = 1'b0;
      exp_err = 1'b0; exp_errop = 4'h0; exp_errst = 10'h0;
      for (int k = 0; k < 3; k++) begin
         push_item(model_out(P_ERR, OP_LUI, 1'b0, 1'b1, MemRdy));
         @(posedge CLK); #1;
      end
      push_item(model_out(P_ERR, OP_LUI, 1'b0, 1'b1, MemRdy));
   endtask

   always @(negedge CLK) begin
      if (q.size() > 0) begin
         item_t e;
         e = q.pop_front();
         chk("state", 32'(State), 32'(e.st));
         chk("strobes", 32'({PCW, MW, IW, RW, FU, SPW}), 32'(e.wr));
         chk("selects", 32'({Jump, LM, IorD, MSrc, SrcB, SPIorD}), 32'(e.sel));
         chk("rwsrc", 32'(RWSrc), 32'(e.rwsrc));
         chk("aluop", 32'(ALUOp), 32'(e.aluop));
         chk("retired", 32'(Retired), 32'(e.ret));
         chk("error", 32'({Error, ErrOp, ErrState}), 32'({e.err, e.errop, e.errst}));
      end
   end

   initial begin
      do_reset();
      issue(OP_ADD, 1'b1, 1'b1, 0, 0);
      issue(OP_J,   1'b1, 1'b1, 0, 0);
      issue(OP_STO, 1'b0, 1'b1, 0, 3);
      issue(OP_SUB, 1'b0, 1'b0, 0, 0);
      issue(OP_ADD, 1'b0, 1'b1, 15, 0);
      issue(OP_STO, 1'b1, 1'b1, 2, 15);
      issue(OP_POP, 1'b0, 1'b1, 0, 15);
      for (int n = 0; n < 160; n++) begin
         logic [3:0] op;
         logic lmc, perf;
         int sf, sm;
         op   = 4'($urandom_range(0, 15));
         lmc  = 1'($urandom % 2);
         perf = (($urandom % 8) != 0);
         sf   = (($urandom % 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         sm   = (($urandom % 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         issue(op, lmc, perf, sf, sm);
      end
      mid_reset();
      issue(OP_CPI, 1'b0, 1'b1, 0, 0);
      err_test();
      do_reset();
      issue(OP_ORI, 1'b1, 1'b1, 1, 0);
      issue(OP_JR,  1'b1, 1'b1, 0, 2);
      repeat (3) @(posedge CLK);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
